veldt_mem_arbiter: RTL and testbench

// Shares the single-port RAM of the Veldt core between instruction fetch (I) and load/store (D).

---
 rtl/veldt_mem_pkg.sv | 22 ++
 rtl/veldt_rsp_pipe.sv | 47 ++++
 rtl/veldt_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_veldt_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/veldt_mem_pkg.sv
// Shared types for the Veldt RAM arbiter: requester owner tags,
// arbitration priority states and the response-pipe slot record.
package veldt_mem_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    D_PRIO = 1'b0,
    I_PRIO = 1'b1
  } prio_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rsp_slot_t;

  localparam rsp_slot_t SLOT_EMPTY = '{valid: 1'b0, owner: OWN_I};

endpackage

// File: rtl/veldt_rsp_pipe.sv
// Read-response tag pipe: DEPTH-deep shift register of {valid, owner}.
// Ports: clk, reset (sync, active-low), push_valid/push_owner enter
// stage 0; flush_i drops I-owned slots as they shift; head = last stage.
module veldt_rsp_pipe
  import veldt_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_valid,
  input  owner_e    push_owner,
  input  logic      flush_i,
  output rsp_slot_t head
);

  rsp_slot_t slot_q [DEPTH];
  rsp_slot_t slot_d [DEPTH];

  // The entry pushed in the flush cycle is a new fetch and must survive,
  // so flush only acts on entries already in flight.
  always_comb begin
    slot_d[0].valid = push_valid;
    slot_d[0].owner = push_owner;
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
      if (flush_i && slot_q[k-1].owner == OWN_I) begin
        slot_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= SLOT_EMPTY;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign head = slot_q[DEPTH-1];

endmodule

// File: rtl/veldt_mem_arbiter.sv
// Single-port RAM arbiter between fetch (I) and load/store (D).
// Ports: i_* fetch side, d_* data side, ram_* RAM command/read data.
module veldt_mem_arbiter
  import veldt_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  input  logic            i_flush,
  output logic            i_rsp_valid,
  output logic [DW-1:0]   i_rsp_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_gnt,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_data,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);

  prio_e           state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  rsp_slot_t       head;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (reset) begin
      unique case (state_q)
        D_PRIO: begin
          if (d_req)      d_gnt = 1'b1;
          else if (i_req) i_gnt = 1'b1;
        end
        I_PRIO: begin
          if (i_req)      i_gnt = 1'b1;
          else if (d_req) d_gnt = 1'b1;
        end
        default: ;
      endcase
      if (i_gnt) begin
        wait_cnt_d = '0;
        state_d    = D_PRIO;
      end else if (i_req) begin
        // I refused this cycle: starve guard.
        if (wait_cnt_q >= WAIT_LAST) state_d = I_PRIO;
        if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // Address/data hold their last value when nothing is issued.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (d_gnt) begin
      ram_addr_d  = {2'b00, d_addr[AW-1:2]};
      ram_wdata_d = d_wdata;
    end else if (i_gnt) begin
      ram_addr_d  = {2'b00, i_addr[AW-1:2]};
    end
  end

  assign ram_en    = i_gnt | d_gnt;
  assign ram_we    = (d_gnt && d_we) ? d_wmask : '0;
  assign ram_addr  = ram_addr_d;
  assign ram_wdata = ram_wdata_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= D_PRIO;
      wait_cnt_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  veldt_rsp_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .reset     (reset),
    .push_valid(i_gnt | (d_gnt & ~d_we)),
    .push_owner(i_gnt ? OWN_I : OWN_D),
    .flush_i   (i_flush),
    .head      (head)
  );

  // A response due during a reset cycle is dropped, not delivered.
  assign i_rsp_valid = reset & head.valid & (head.owner == OWN_I);
  assign d_rsp_valid = reset & head.valid & (head.owner == OWN_D);
  assign i_rsp_data  = ram_rdata;
  assign d_rsp_data  = ram_rdata;

endmodule

// File: tb/tb_veldt_mem_arbiter.sv
// Directed bench for veldt_mem_arbiter: latency-1 and latency-2
// instances share stimulus; table rows plus hand-written sequences.
module tb_veldt_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_req, i_flush, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, ram_rdata;
  logic [3:0]  d_wmask;

  logic        a_ig, a_dg, a_irv, a_drv, a_en;
  logic [31:0] a_ird, a_drd, a_addr, a_wd;
  logic [3:0]  a_we;
  logic        b_ig, b_dg, b_irv, b_drv, b_en;
  logic [31:0] b_ird, b_drd, b_addr, b_wd;
  logic [3:0]  b_we;

  veldt_mem_arbiter #(
    .AW(32), .DW(32), .RD_LATENCY(1), .MAX_WAIT(4)
  ) dut_a (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(a_ig), .i_flush(i_flush),
    .i_rsp_valid(a_irv), .i_rsp_data(a_ird),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(a_dg), .d_rsp_valid(a_drv),
    .d_rsp_data(a_drd), .ram_en(a_en), .ram_we(a_we),
    .ram_addr(a_addr), .ram_wdata(a_wd), .ram_rdata(ram_rdata)
  );

  veldt_mem_arbiter #(
    .AW(32), .DW(32), .RD_LATENCY(2), .MAX_WAIT(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(b_ig), .i_flush(i_flush),
    .i_rsp_valid(b_irv), .i_rsp_data(b_ird),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(b_dg), .d_rsp_valid(b_drv),
    .d_rsp_data(b_drd), .ram_en(b_en), .ram_we(b_we),
    .ram_addr(b_addr), .ram_wdata(b_wd), .ram_rdata(ram_rdata)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] rdata;
    logic        e_ig;
    logic        e_dg;
    logic        e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_irv;
    logic        e_drv;
  } vec_t;

  vec_t vt [11];

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    i_req   = 1'b0;
    i_addr  = 32'h0;
    i_flush = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_wmask = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
               1'b1, 1'b0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13,
               1'b0, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0,
               1'b0, 1'b1, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h55,
               1'b0, 1'b1, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h66,
               1'b0, 1'b1, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h77,
               1'b0, 1'b1, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h88,
               1'b1, 1'b0, 1'b1, 4'h0, 32'h41, 32'h0, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h93,
               1'b0, 1'b1, 1'b1, 4'h0, 32'h80, 32'h0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99,
               1'b0, 1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0011,
               32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'hAABBCCDD,
               1'b0, 1'b0};
    vt[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
               1'b0, 1'b0, 1'b0, 4'h0, 32'h8, 32'hAABBCCDD, 1'b0, 1'b0};

    reset     = 1'b0;
    ram_rdata = 32'h0;
    idle();
    #1;

    // Reset held with both requesters active.
    for (int c = 0; c < 3; c++) begin
      i_req  = 1'b1;
      i_addr = 32'h100;
      d_req  = 1'b1;
      d_addr = 32'h200;
      #3;
      chk("rst_a_ig",  32'(a_ig),  32'h0);
      chk("rst_a_dg",  32'(a_dg),  32'h0);
      chk("rst_a_en",  32'(a_en),  32'h0);
      chk("rst_a_irv", 32'(a_irv), 32'h0);
      chk("rst_a_drv", 32'(a_drv), 32'h0);
      chk("rst_b_ig",  32'(b_ig),  32'h0);
      chk("rst_b_dg",  32'(b_dg),  32'h0);
      chk("rst_b_en",  32'(b_en),  32'h0);
      step();
    end
    reset = 1'b1;
    idle();

    // Table: fetch, starvation guard, store (latency-1 instance).
    for (int r = 0; r < 11; r++) begin
      i_req     = vt[r].i_req;
      i_addr    = vt[r].i_addr;
      d_req     = vt[r].d_req;
      d_we      = vt[r].d_we;
      d_addr    = vt[r].d_addr;
      d_wdata   = vt[r].d_wdata;
      d_wmask   = vt[r].d_wmask;
      ram_rdata = vt[r].rdata;
      #3;
      chk($sformatf("v%0d_i_gnt", r), 32'(a_ig),  32'(vt[r].e_ig));
      chk($sformatf("v%0d_d_gnt", r), 32'(a_dg),  32'(vt[r].e_dg));
      chk($sformatf("v%0d_en", r),    32'(a_en),  32'(vt[r].e_en));
      chk($sformatf("v%0d_we", r),    32'(a_we),  32'(vt[r].e_we));
      chk($sformatf("v%0d_addr", r),  a_addr,     vt[r].e_addr);
      chk($sformatf("v%0d_wdata", r), a_wd,       vt[r].e_wd);
      chk($sformatf("v%0d_irv", r),   32'(a_irv), 32'(vt[r].e_irv));
      chk($sformatf("v%0d_drv", r),   32'(a_drv), 32'(vt[r].e_drv));
      if (vt[r].e_irv)
        chk($sformatf("v%0d_idata", r), a_ird, vt[r].rdata);
      if (vt[r].e_drv)
        chk($sformatf("v%0d_ddata", r), a_drd, vt[r].rdata);
      step();
    end
    idle();
    ram_rdata = 32'h0;

    // Flush of an in-flight fetch on the latency-2 instance.
    i_req  = 1'b1;
    i_addr = 32'h300;
    #3;
    chk("fl_c0_ig", 32'(b_ig), 32'h1);
    step();
    idle();
    d_req   = 1'b1;
    d_addr  = 32'h400;
    i_flush = 1'b1;
    #3;
    chk("fl_c1_dg",  32'(b_dg),  32'h1);
    chk("fl_c1_irv", 32'(b_irv), 32'h0);
    step();
    idle();
    #3;
    chk("fl_c2_irv", 32'(b_irv), 32'h0);
    chk("fl_c2_drv", 32'(b_drv), 32'h0);
    step();
    ram_rdata = 32'hCAFE0001;
    #3;
    chk("fl_c3_drv", 32'(b_drv), 32'h1);
    chk("fl_c3_dd",  b_drd,      32'hCAFE0001);
    chk("fl_c3_irv", 32'(b_irv), 32'h0);
    step();
    #3;
    chk("fl_c4_drv", 32'(b_drv), 32'h0);
    chk("fl_c4_irv", 32'(b_irv), 32'h0);
    step();

    // Fetch granted in the flush cycle survives.
    i_req   = 1'b1;
    i_addr  = 32'h304;
    i_flush = 1'b1;
    #3;
    chk("ff_c0_ig", 32'(b_ig), 32'h1);
    step();
    idle();
    #3;
    chk("ff_c1_irv", 32'(b_irv), 32'h0);
    step();
    ram_rdata = 32'h12345678;
    #3;
    chk("ff_c2_irv", 32'(b_irv), 32'h1);
    chk("ff_c2_id",  b_ird,      32'h12345678);
    step();
    ram_rdata = 32'h0;

    // Reset with reads in flight.
    i_req  = 1'b1;
    i_addr = 32'h500;
    #3;
    chk("rr_c0_ig", 32'(a_ig), 32'h1);
    step();
    idle();
    d_req  = 1'b1;
    d_addr = 32'h600;
    #3;
    chk("rr_c1_dg", 32'(a_dg), 32'h1);
    step();
    idle();
    reset = 1'b0;
    #3;
    chk("rr_c2_a_irv", 32'(a_irv), 32'h0);
    chk("rr_c2_a_drv", 32'(a_drv), 32'h0);
    chk("rr_c2_b_irv", 32'(b_irv), 32'h0);
    chk("rr_c2_b_drv", 32'(b_drv), 32'h0);
    step();
    reset = 1'b1;
    #3;
    chk("rr_c3_a_irv", 32'(a_irv), 32'h0);
    chk("rr_c3_a_drv", 32'(a_drv), 32'h0);
    chk("rr_c3_b_irv", 32'(b_irv), 32'h0);
    chk("rr_c3_b_drv", 32'(b_drv), 32'h0);
    step();
    i_req  = 1'b1;
    i_addr = 32'h504;
    d_req  = 1'b1;
    d_addr = 32'h604;
    #3;
    chk("rr_c4_dg",   32'(a_dg), 32'h1);
    chk("rr_c4_ig",   32'(a_ig), 32'h0);
    chk("rr_c4_addr", a_addr,    32'h181);
    step();
    idle();
    ram_rdata = 32'h0000BEEF;
    #3;
    chk("rr_c5_drv", 32'(a_drv), 32'h1);
    chk("rr_c5_dd",  a_drd,      32'h0000BEEF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
